// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver and scan-code decoder.
// Samples PS2_CLK/PS2_DATA through a synchroniser and glitch filter, deframes 11-bit packets
// (start, d0..d7, odd parity, stop) with a frame timeout, folds E0/F0 prefixes into key events
// and queues them in a FIFO with a valid/ready handshake.
// Ports:
//   CLK, RST_N        system clock, asynchronous active-low reset
//   PS2_CLK, PS2_DATA asynchronous keyboard lines
//   EV_VALID/EV_READY event handshake; EV_DATA = {ext, brk, code[7:0]} of the FIFO head
//   LAST_CODE         last correctly received byte (prefixes included)
//   FRAME_ERR         pulse on start/parity/stop error or timeout
//   OVERFLOW          pulse when an event is dropped on a full FIFO
//   BAT_OK, BAT_ERR   pulse on 0xAA / 0xFC received in IDLE
module ps2_key_receiver #(
  parameter int unsigned CLK_DIV       = 250,
  parameter int unsigned FILTER_LEN    = 4,
  parameter int unsigned TIMEOUT_TICKS = 4000,
  parameter int unsigned FIFO_DEPTH    = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic       EV_VALID,
  input  logic       EV_READY,
  output logic [9:0] EV_DATA,
  output logic [7:0] LAST_CODE,
  output logic       FRAME_ERR,
  output logic       OVERFLOW,
  output logic       BAT_OK,
  output logic       BAT_ERR
);

  localparam int unsigned DivW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned ToW  = $clog2(TIMEOUT_TICKS + 1);
  localparam int unsigned Aw   = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StE0, StF0, StE0F0} state_e;

  logic [1:0]            clk_sync_q, data_sync_q;
  logic [DivW-1:0]       tick_cnt_q, tick_cnt_d;
  logic [FILTER_LEN-1:0] hist_q, hist_d;
  logic                  filt_q, filt_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [9:0]            shift_q, shift_d;
  logic [ToW-1:0]        to_cnt_q, to_cnt_d;
  logic                  byte_stb_q, byte_stb_d;
  logic [7:0]            byte_q, byte_d;
  logic                  frame_err_q, frame_err_d;
  logic [7:0]            last_code_q, last_code_d;
  state_e                state_q, state_d;
  logic                  push_q, push_d;
  logic [9:0]            push_data_q, push_data_d;
  logic                  bat_ok_q, bat_ok_d, bat_err_q, bat_err_d;
  logic [Aw:0]           wptr_q, wptr_d, rptr_q, rptr_d;
  logic                  ovf_q, ovf_d;
  logic [9:0]            mem_q [FIFO_DEPTH];
  logic                  tick, fall, empty, full, pop, wr;

  // Tick generator and glitch filter
  assign tick = (tick_cnt_q == DivW'(CLK_DIV - 1));

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    hist_d     = hist_q;
    filt_d     = filt_q;
    if (tick) begin
      hist_d = FILTER_LEN'({hist_q, clk_sync_q[1]});
      if (hist_d == '0)  filt_d = 1'b0;
      else if (&hist_d)  filt_d = 1'b1;
    end
  end

  assign fall = filt_q & ~filt_d;

  // Deframer with timeout
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    to_cnt_d    = to_cnt_q;
    byte_stb_d  = 1'b0;
    byte_d      = byte_q;
    frame_err_d = 1'b0;
    last_code_d = last_code_q;
    if (fall) begin
      to_cnt_d = '0;
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = '0;
        // shift_q holds start, d0..d7, parity; the stop bit is the current sample
        if (!shift_q[0] && data_sync_q[1] && (^shift_q[9:1])) begin
          byte_stb_d  = 1'b1;
          byte_d      = shift_q[8:1];
          last_code_d = shift_q[8:1];
        end else begin
          frame_err_d = 1'b1;
        end
      end else begin
        shift_d[bit_cnt_q] = data_sync_q[1];
        bit_cnt_d          = bit_cnt_q + 1'b1;
      end
    end else if (tick && (bit_cnt_q != '0)) begin
      if (to_cnt_q == ToW'(TIMEOUT_TICKS - 1)) begin
        frame_err_d = 1'b1;
        bit_cnt_d   = '0;
        to_cnt_d    = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  // Prefix decoder
  always_comb begin
    state_d     = state_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    bat_ok_d    = 1'b0;
    bat_err_d   = 1'b0;
    if (frame_err_q) begin
      state_d = StIdle;
    end else if (byte_stb_q) begin
      unique case (state_q)
        StIdle: begin
          if (byte_q == 8'hE0)      state_d = StE0;
          else if (byte_q == 8'hF0) state_d = StF0;
          else if (byte_q == 8'hAA) bat_ok_d = 1'b1;
          else if (byte_q == 8'hFC) bat_err_d = 1'b1;
          else begin
            push_d      = 1'b1;
            push_data_d = {2'b00, byte_q};
          end
        end
        StE0: begin
          if (byte_q == 8'hF0) begin
            state_d = StE0F0;
          end else begin
            push_d      = 1'b1;
            push_data_d = {2'b10, byte_q};
            state_d     = StIdle;
          end
        end
        StF0: begin
          push_d      = 1'b1;
          push_data_d = {2'b01, byte_q};
          state_d     = StIdle;
        end
        StE0F0: begin
          push_d      = 1'b1;
          push_data_d = {2'b11, byte_q};
          state_d     = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Event FIFO; a full FIFO still accepts a push when the head is popped in the same cycle
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[Aw] != rptr_q[Aw]) && (wptr_q[Aw-1:0] == rptr_q[Aw-1:0]);
  assign pop   = !empty && EV_READY;
  assign wr    = push_q && (!full || pop);

  always_comb begin
    wptr_d = wr  ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop ? rptr_q + 1'b1 : rptr_q;
    ovf_d  = push_q && full && !pop;
  end

  always_ff @(posedge CLK) begin
    if (wr) mem_q[wptr_q[Aw-1:0]] <= push_data_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      tick_cnt_q  <= '0;
      hist_q      <= '1;
      filt_q      <= 1'b1;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      to_cnt_q    <= '0;
      byte_stb_q  <= 1'b0;
      byte_q      <= '0;
      frame_err_q <= 1'b0;
      last_code_q <= '0;
      state_q     <= StIdle;
      push_q      <= 1'b0;
      push_data_q <= '0;
      bat_ok_q    <= 1'b0;
      bat_err_q   <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], PS2_CLK};
      data_sync_q <= {data_sync_q[0], PS2_DATA};
      tick_cnt_q  <= tick_cnt_d;
      hist_q      <= hist_d;
      filt_q      <= filt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      to_cnt_q    <= to_cnt_d;
      byte_stb_q  <= byte_stb_d;
      byte_q      <= byte_d;
      frame_err_q <= frame_err_d;
      last_code_q <= last_code_d;
      state_q     <= state_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      bat_ok_q    <= bat_ok_d;
      bat_err_q   <= bat_err_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      ovf_q       <= ovf_d;
    end
  end

  assign EV_VALID  = !empty;
  assign EV_DATA   = empty ? '0 : mem_q[rptr_q[Aw-1:0]];
  assign LAST_CODE = last_code_q;
  assign FRAME_ERR = frame_err_q;
  assign OVERFLOW  = ovf_q;
  assign BAT_OK    = bat_ok_q;
  assign BAT_ERR   = bat_err_q;

endmodule

// File: tb/tb_ps2_key_receiver.sv
module tb_ps2_key_receiver;

  logic       clk, rst_n, ps2_clk, ps2_data, ev_valid, ev_ready;
  logic [9:0] ev_data;
  logic [7:0] last_code;
  logic       frame_err, overflow, bat_ok, bat_err;

  int checks = 0;
  int fails  = 0;

  // Pulse counters and accepted-event log, written only by the monitor
  int         err_cnt = 0, ovf_cnt = 0, bok_cnt = 0, berr_cnt = 0;
  int         ev_n = 0;
  logic [9:0] evs [256];

  ps2_key_receiver #(
    .CLK_DIV(4), .FILTER_LEN(2), .TIMEOUT_TICKS(50), .FIFO_DEPTH(4)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data),
    .EV_VALID(ev_valid), .EV_READY(ev_ready), .EV_DATA(ev_data),
    .LAST_CODE(last_code), .FRAME_ERR(frame_err), .OVERFLOW(overflow),
    .BAT_OK(bat_ok), .BAT_ERR(bat_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) err_cnt++;
    if (overflow)  ovf_cnt++;
    if (bat_ok)    bok_cnt++;
    if (bat_err)   berr_cnt++;
    if (ev_valid && ev_ready && ev_n < 256) begin
      evs[ev_n] = ev_data;
      ev_n++;
    end
  end

  // Sends the first n bits of an 11-bit frame LSB-first; bit period 80 CLK
  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      repeat (20) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (40) @(posedge clk);
      ps2_clk = 1'b1;
      repeat (20) @(posedge clk);
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par);
    logic [10:0] f;
    f = {1'b1, (~^d) ^ bad_par, d, 1'b0};
    send_bits(f, 11);
    repeat (100) @(posedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (ev_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", ev_valid); end
    checks++; if (ev_data !== 10'h0) begin fails++; $display("FAIL reset_data: got %h want 000", ev_data); end
    checks++; if (last_code !== 8'h0) begin fails++; $display("FAIL reset_last: got %h want 00", last_code); end
    checks++; if ({frame_err, overflow, bat_ok, bat_err} !== 4'b0) begin
      fails++; $display("FAIL reset_pulses: got %b want 0000", {frame_err, overflow, bat_ok, bat_err});
    end
  endtask

  task automatic test_make;
    int e0, n0;
    e0 = err_cnt; n0 = ev_n;
    send_frame(8'h1C, 1'b0);
    checks++; if (ev_n - n0 !== 1) begin fails++; $display("FAIL make_count: got %0d want 1", ev_n - n0); end
    checks++; if (evs[n0] !== 10'h01C) begin fails++; $display("FAIL make_data: got %h want 01c", evs[n0]); end
    checks++; if (last_code !== 8'h1C) begin fails++; $display("FAIL make_last: got %h want 1c", last_code); end
    checks++; if (err_cnt - e0 !== 0) begin fails++; $display("FAIL make_err: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_ext_break;
    int n0;
    n0 = ev_n;
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    checks++; if (ev_n - n0 !== 1) begin fails++; $display("FAIL extbrk_count: got %0d want 1", ev_n - n0); end
    checks++; if (evs[n0] !== 10'h375) begin fails++; $display("FAIL extbrk_data: got %h want 375", evs[n0]); end
    checks++; if (last_code !== 8'h75) begin fails++; $display("FAIL extbrk_last: got %h want 75", last_code); end
  endtask

  task automatic test_parity;
    int e0, n0;
    e0 = err_cnt; n0 = ev_n;
    send_frame(8'h16, 1'b1);
    checks++; if (err_cnt - e0 !== 1) begin fails++; $display("FAIL parity_err: got %0d want 1", err_cnt - e0); end
    checks++; if (ev_n - n0 !== 0) begin fails++; $display("FAIL parity_noev: got %0d want 0", ev_n - n0); end
    checks++; if (last_code !== 8'h75) begin fails++; $display("FAIL parity_last: got %h want 75", last_code); end
    send_frame(8'hF0, 1'b0);
    send_frame(8'h16, 1'b0);
    checks++; if (ev_n - n0 !== 1) begin fails++; $display("FAIL parity_brk_count: got %0d want 1", ev_n - n0); end
    checks++; if (evs[n0] !== 10'h116) begin fails++; $display("FAIL parity_brk_data: got %h want 116", evs[n0]); end
  endtask

  task automatic test_timeout;
    int e0, n0;
    logic [10:0] f;
    e0 = err_cnt; n0 = ev_n;
    f = {1'b1, ~^8'h6B, 8'h6B, 1'b0};
    send_bits(f, 5);
    repeat (400) @(posedge clk);
    checks++; if (err_cnt - e0 !== 1) begin fails++; $display("FAIL timeout_err: got %0d want 1", err_cnt - e0); end
    send_frame(8'h6B, 1'b0);
    checks++; if (ev_n - n0 !== 1) begin fails++; $display("FAIL timeout_next_count: got %0d want 1", ev_n - n0); end
    checks++; if (evs[n0] !== 10'h06B) begin fails++; $display("FAIL timeout_next_data: got %h want 06b", evs[n0]); end
  endtask

  task automatic test_overflow;
    logic [7:0] keys [5];
    int o0, n0;
    keys = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24};
    @(posedge clk); #1 ev_ready = 1'b0;
    o0 = ovf_cnt; n0 = ev_n;
    for (int i = 0; i < 5; i++) send_frame(keys[i], 1'b0);
    @(negedge clk);
    checks++; if (ovf_cnt - o0 !== 1) begin fails++; $display("FAIL ovf_pulse: got %0d want 1", ovf_cnt - o0); end
    checks++; if (ev_valid !== 1'b1) begin fails++; $display("FAIL ovf_valid: got %b want 1", ev_valid); end
    checks++; if (ev_data !== 10'h01C) begin fails++; $display("FAIL ovf_head: got %h want 01c", ev_data); end
    @(posedge clk); #1 ev_ready = 1'b1;
    repeat (20) @(posedge clk);
    checks++; if (ev_n - n0 !== 4) begin fails++; $display("FAIL ovf_drain_count: got %0d want 4", ev_n - n0); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (evs[n0 + i] !== {2'b00, keys[i]}) begin
        fails++; $display("FAIL ovf_drain_%0d: got %h want %h", i, evs[n0 + i], {2'b00, keys[i]});
      end
    end
    @(negedge clk);
    checks++; if (ev_valid !== 1'b0) begin fails++; $display("FAIL ovf_empty: got %b want 0", ev_valid); end
  endtask

  task automatic test_bat;
    int b0, be0, n0;
    b0 = bok_cnt; be0 = berr_cnt; n0 = ev_n;
    send_frame(8'hAA, 1'b0);
    checks++; if (bok_cnt - b0 !== 1) begin fails++; $display("FAIL bat_ok: got %0d want 1", bok_cnt - b0); end
    checks++; if (last_code !== 8'hAA) begin fails++; $display("FAIL bat_last: got %h want aa", last_code); end
    send_frame(8'hFC, 1'b0);
    checks++; if (berr_cnt - be0 !== 1) begin fails++; $display("FAIL bat_err: got %0d want 1", berr_cnt - be0); end
    checks++; if (ev_n - n0 !== 0) begin fails++; $display("FAIL bat_noev: got %0d want 0", ev_n - n0); end
  endtask

  task automatic test_reset_mid;
    int n0;
    send_frame(8'hE0, 1'b0);
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++; if (last_code !== 8'h0) begin fails++; $display("FAIL rstmid_last: got %h want 00", last_code); end
    checks++; if ({ev_valid, ev_data} !== 11'h0) begin
      fails++; $display("FAIL rstmid_ev: got %h want 000", {ev_valid, ev_data});
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    n0 = ev_n;
    send_frame(8'h74, 1'b0);
    checks++; if (ev_n - n0 !== 1) begin fails++; $display("FAIL rstmid_count: got %0d want 1", ev_n - n0); end
    checks++; if (evs[n0] !== 10'h074) begin fails++; $display("FAIL rstmid_data: got %h want 074", evs[n0]); end
  endtask

  initial begin
    rst_n    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    ev_ready = 1'b1;
    repeat (5) @(posedge clk);
    test_reset;
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    test_make;
    test_ext_break;
    test_parity;
    test_timeout;
    test_overflow;
    test_bat;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ps2_key_receiver.md
# ps2_key_receiver

Parametrised PS/2 keyboard receiver and scan-code decoder. It samples the keyboard PS2_CLK/PS2_DATA lines through a synchroniser and glitch filter, then deframes 11-bit packets with full start/parity/stop checking and a frame timeout. It folds E0/F0 prefixes into complete key events and queues them in a FIFO with a valid/ready handshake. It sits between the PS2 pins and any consumer logic (LED display, game control), replacing the fixed single-register receiver.

## Interface
- CLK_DIV, 250: sample-tick divisor; one tick every CLK_DIV CLK cycles (≥2).
- FILTER_LEN, 4: consecutive equal tick samples required to change the filtered PS2 clock (≥1).
- TIMEOUT_TICKS, 4000: ticks without a falling edge before a partial frame is discarded.
- FIFO_DEPTH, 8: event FIFO entries (power of two, ≥2).

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- PS2_CLK  in  1  keyboard clock, asynchronous.
- PS2_DATA  in  1  keyboard data, asynchronous.
- EV_VALID  out  1  FIFO head holds an event.
- EV_READY  in  1  consumer accepts the head event.
- EV_DATA  out  10  {ext, brk, code[7:0]} of the FIFO head.
- LAST_CODE  out  8  last correctly received data byte, including prefixes.
- FRAME_ERR  out  1  one-cycle pulse on parity/start/stop error or timeout.
- OVERFLOW  out  1  one-cycle pulse when an event is dropped because the FIFO is full.
- BAT_OK  out  1  one-cycle pulse on 0xAA received in IDLE.
- BAT_ERR  out  1  one-cycle pulse on 0xFC received in IDLE.

## Operation
- **Synchroniser.** PS2_CLK and PS2_DATA each pass through 2 CLK flops. The tick counter runs 0..CLK_DIV-1, and a tick is asserted while count == CLK_DIV-1.
- **Filter.** On each tick, the synced clock is shifted into a FILTER_LEN history. The filtered clock goes 0 when all history bits are 0 and 1 when all are 1; otherwise it holds. A 1→0 transition of the filtered clock is a falling edge, and it samples the synced PS2_DATA on that tick.
- **Deframer.** Bits arrive LSB-first: start(0), d0..d7, odd parity, stop(1). The bit counter runs 0..10.
  - After bit 10 the frame is valid iff start==0, stop==1, and XOR(d0..d7, parity)==1.
  - A valid frame yields a byte strobe. An invalid frame pulses FRAME_ERR. Either way the counter returns to 0.
  - The timeout counter clears on every falling edge and increments per tick while the bit counter ≠0. On reaching TIMEOUT_TICKS it discards the frame, clears the counter, and pulses FRAME_ERR.
- **Decoder FSM.** States IDLE, E0, F0, E0F0. On each byte strobe:
  - IDLE: 0xE0→E0; 0xF0→F0; 0xAA→BAT_OK; 0xFC→BAT_ERR; any other byte emits {0,0,byte}.
  - E0: 0xF0→E0F0; other byte emits {1,0,byte}→IDLE.
  - F0: emits {0,1,byte}→IDLE.
  - E0F0: emits {1,1,byte}→IDLE.
  - A FRAME_ERR in any state forces IDLE, discarding pending prefixes.
- **LAST_CODE** updates on every byte strobe.
- **FIFO.** Event pushes write the FIFO. A pop occurs when EV_VALID && EV_READY.
  - Push while full and no pop in the same cycle: the event is dropped and OVERFLOW pulses.
  - Push and pop in the same cycle while full: both succeed.
  - Push while empty: no bypass, the event is visible only from the next cycle.
- **Reset values.** All outputs are 0 and the FSM is in IDLE. The FIFO is empty, the bit, timeout and tick counters are 0, and the filtered clock and filter history are 1.
- **Reset mid-frame** discards the partial frame and any pending prefix.

## Timing
- Falling-edge latency: 2 CLK (sync) plus FILTER_LEN ticks from the pin edge to the registered edge.
- The byte strobe and FRAME_ERR are registered 1 cycle after the tick carrying the 11th falling edge.
- FSM event push is registered 1 cycle after the byte strobe. EV_VALID/EV_DATA update 1 cycle after the push (from empty).
- BAT_OK/BAT_ERR pulse in the same cycle as an event push would.
- After a pop, EV_DATA shows the next entry on the following cycle. EV_DATA is stable while EV_VALID && !EV_READY.

## Test plan
(CLK_DIV=4, FILTER_LEN=2, TIMEOUT_TICKS=50, FIFO_DEPTH=4; the PS2 bit period is ≥40 CLK.)
- Frame 0x1C with correct parity → event 0x01C appears; LAST_CODE=0x1C; FRAME_ERR never pulses.
- Sequence E0, F0, 75 → exactly one event 0x375 (ext=1, brk=1); LAST_CODE=0x75.
- Frame 0x16 with wrong parity → one FRAME_ERR pulse, no event. A following F0, 16 then yields 0x116.
- 5 bits then silence for >50 ticks → FRAME_ERR pulse. The next full 0x6B frame yields 0x06B.
- Five keys sent with EV_READY=0 → 4 events queued, one OVERFLOW pulse. Draining with EV_READY=1 returns the first 4 codes in order.
- 0xAA in IDLE → BAT_OK pulse with no event. RST_N asserted after an E0 byte → all outputs 0; a subsequent 0x74 yields 0x074.
